// File: rtl/execute_stage_md.sv
// MIPS execute stage: ALU, operand forwarding, EX/MEM register and, when
// EXECUTE_MD_UNIT_EN is defined, an iterative multiply/divide unit with HI/LO.
module execute_stage_md #(
    parameter int unsigned WIDTH             = 32,
    parameter int unsigned REG_ADDR_WIDTH    = 5,
    parameter int unsigned ALU_CONTROL_WIDTH = 3
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [ALU_CONTROL_WIDTH-1:0] ALUControlE,
    input  logic [2:0]                   MDOpE,
    input  logic                         RegWriteE,
    input  logic                         MemtoRegE,
    input  logic                         MemWriteE,
    input  logic                         RegDstE,
    input  logic                         ALUSrcE,
    input  logic [WIDTH-1:0]             RD1_E,
    input  logic [WIDTH-1:0]             RD2_E,
    input  logic [WIDTH-1:0]             SignImmE,
    input  logic [WIDTH-1:0]             ResultW,
    input  logic [REG_ADDR_WIDTH-1:0]    RsE,
    input  logic [REG_ADDR_WIDTH-1:0]    RtE,
    input  logic [REG_ADDR_WIDTH-1:0]    RdE,
    input  logic [1:0]                   ForwardAE,
    input  logic [1:0]                   ForwardBE,
    output logic                         StallE,
    output logic                         MDBusy,
    output logic                         RegWriteM,
    output logic                         MemtoRegM,
    output logic                         MemWriteM,
    output logic [WIDTH-1:0]             ALUOutM,
    output logic [WIDTH-1:0]             WriteDataM,
    output logic [REG_ADDR_WIDTH-1:0]    WriteRegM
);

    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_AND = ALU_CONTROL_WIDTH'(3'b000);
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OR  = ALU_CONTROL_WIDTH'(3'b001);
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_ADD = ALU_CONTROL_WIDTH'(3'b010);
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SUB = ALU_CONTROL_WIDTH'(3'b110);
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SLT = ALU_CONTROL_WIDTH'(3'b111);

    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;

    logic [WIDTH-1:0]          srca;
    logic [WIDTH-1:0]          write_data;
    logic [WIDTH-1:0]          srcb;
    logic [WIDTH-1:0]          alu_y;
    logic [WIDTH-1:0]          result;
    logic [REG_ADDR_WIDTH-1:0] write_reg;
    logic                      is_md_start;
    logic                      is_mf_hi;
    logic                      is_mf_lo;
    logic                      unused_rs;

    assign unused_rs = ^RsE;

    // Forwarding muxes; ALUOutM is this stage's own M register
    always_comb begin : fwd_mux
        case (ForwardAE)
            2'b00:   srca = RD1_E;
            2'b01:   srca = ResultW;
            2'b10:   srca = ALUOutM;
            default: srca = '0;
        endcase
        case (ForwardBE)
            2'b00:   write_data = RD2_E;
            2'b01:   write_data = ResultW;
            2'b10:   write_data = ALUOutM;
            default: write_data = '0;
        endcase
    end

    assign srcb      = ALUSrcE ? SignImmE : write_data;
    assign write_reg = RegDstE ? RdE : RtE;

    always_comb begin : alu
        case (ALUControlE)
            ALU_AND: alu_y = srca & srcb;
            ALU_OR:  alu_y = srca | srcb;
            ALU_ADD: alu_y = srca + srcb;
            ALU_SUB: alu_y = srca - srcb;
            ALU_SLT: alu_y = WIDTH'($signed(srca) < $signed(srcb));
            default: alu_y = '0;
        endcase
    end

    assign is_md_start = (MDOpE == MD_MULT) || (MDOpE == MD_MULTU) ||
                         (MDOpE == MD_DIV)  || (MDOpE == MD_DIVU);
    assign is_mf_hi    = (MDOpE == MD_MFHI);
    assign is_mf_lo    = (MDOpE == MD_MFLO);

`ifdef EXECUTE_MD_UNIT_EN
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             state, state_d;
    logic [CW-1:0]      count, count_d;
    logic [2*WIDTH-1:0] acc, acc_d;
    logic [WIDTH-1:0]   opa, opa_d, opb, opb_d, hi, hi_d, lo, lo_d;
    logic               neg_res, neg_res_d, neg_rem, neg_rem_d, busy;
    logic               is_signed_op, is_div_op, a_neg, b_neg, last;
    logic [WIDTH:0]     mul_sum, div_diff;
    logic [2*WIDTH:0]   div_shift;
    logic [2*WIDTH-1:0] prod_step, quo_step, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, dvd_orig;

    assign is_signed_op = (MDOpE == MD_MULT) || (MDOpE == MD_DIV);
    assign is_div_op    = (MDOpE == MD_DIV)  || (MDOpE == MD_DIVU);
    assign a_neg        = is_signed_op & srca[WIDTH-1];
    assign b_neg        = is_signed_op & srcb[WIDTH-1];
    assign last         = (count == CW'(WIDTH - 1));

    // One shift-add step and one restoring-divide step over the shared accumulator
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    assign prod_step = {mul_sum, acc[WIDTH-1:1]};
    assign div_shift = {acc, 1'b0};
    assign div_diff  = div_shift[2*WIDTH:WIDTH] - {1'b0, opb};
    assign quo_step  = div_diff[WIDTH] ? div_shift[2*WIDTH-1:0]
                                       : {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};

    assign prod_fix = neg_res ? -prod_step : prod_step;
    assign quo_fix  = neg_res ? -quo_step[WIDTH-1:0] : quo_step[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -quo_step[2*WIDTH-1:WIDTH] : quo_step[2*WIDTH-1:WIDTH];
    assign dvd_orig = neg_rem ? -opa : opa;

    always_comb begin : md_next
        state_d   = state;
        count_d   = count;
        acc_d     = acc;
        opa_d     = opa;
        opb_d     = opb;
        hi_d      = hi;
        lo_d      = lo;
        neg_res_d = neg_res;
        neg_rem_d = neg_rem;
        case (state)
            S_IDLE: begin
                if (is_md_start) begin
                    opa_d     = a_neg ? -srca : srca;
                    opb_d     = b_neg ? -srcb : srcb;
                    acc_d     = {{WIDTH{1'b0}}, opa_d};
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    count_d   = '0;
                    state_d   = is_div_op ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                acc_d   = prod_step;
                count_d = count + CW'(1);
                if (last) begin
                    hi_d    = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d    = prod_fix[WIDTH-1:0];
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                acc_d   = quo_step;
                count_d = count + CW'(1);
                if (last) begin
                    // Divide by zero: all-ones quotient, dividend left in HI
                    hi_d    = (opb == '0) ? dvd_orig : rem_fix;
                    lo_d    = (opb == '0) ? '1 : quo_fix;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin : md_regs
        if (!RST) begin
            state   <= S_IDLE;
            count   <= '0;
            acc     <= '0;
            opa     <= '0;
            opb     <= '0;
            hi      <= '0;
            lo      <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            count   <= count_d;
            acc     <= acc_d;
            opa     <= opa_d;
            opb     <= opb_d;
            hi      <= hi_d;
            lo      <= lo_d;
            neg_res <= neg_res_d;
            neg_rem <= neg_rem_d;
            busy    <= (state_d != S_IDLE);
        end
    end

    assign MDBusy = busy;
    assign StallE = busy & (is_md_start | is_mf_hi | is_mf_lo);
    assign result = is_mf_hi ? hi : (is_mf_lo ? lo : alu_y);
`else
    assign MDBusy = 1'b0;
    assign StallE = 1'b0;
    assign result = (is_mf_hi | is_mf_lo) ? '0 : alu_y;
`endif

    // EX/MEM register; a stalled instruction leaves a bubble and data holds
    always_ff @(posedge CLK or negedge RST) begin : m_regs
        if (!RST) begin
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            WriteRegM  <= '0;
        end else if (StallE) begin
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            WriteRegM  <= '0;
        end else begin
            RegWriteM  <= RegWriteE & ~is_md_start;
            MemtoRegM  <= MemtoRegE;
            MemWriteM  <= MemWriteE;
            ALUOutM    <= result;
            WriteDataM <= write_data;
            WriteRegM  <= write_reg;
        end
    end

endmodule

// File: tb/tb_execute_stage_md.sv
// Self-checking bench for execute_stage_md; follows EXECUTE_MD_UNIT_EN for its expectations.
module tb_execute_stage_md;

`ifdef EXECUTE_MD_UNIT_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic        CLK, RST;
    logic [2:0]  ALUControlE, MDOpE;
    logic        RegWriteE, MemtoRegE, MemWriteE, RegDstE, ALUSrcE;
    logic [31:0] RD1_E, RD2_E, SignImmE, ResultW;
    logic [4:0]  RsE, RtE, RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallE, MDBusy, RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: expected M register, HI/LO, cycles left in MD op
    logic [31:0] e_alu, e_wd, m_hi, m_lo, p_hi, p_lo;
    logic [4:0]  e_wr;
    logic        e_rw, e_mtr, e_mw;
    int          busy_left;

    execute_stage_md dut (
        .CLK(CLK), .RST(RST), .ALUControlE(ALUControlE), .MDOpE(MDOpE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .RegDstE(RegDstE), .ALUSrcE(ALUSrcE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .SignImmE(SignImmE), .ResultW(ResultW), .RsE(RsE), .RtE(RtE), .RdE(RdE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallE(StallE), .MDBusy(MDBusy),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd6: return a - b;
            3'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] reg_val);
        case (s)
            2'd0: return reg_val;
            2'd1: return ResultW;
            2'd2: return e_alu;
            default: return 32'd0;
        endcase
    endfunction

    // HI/LO from plain 64-bit arithmetic (division truncates toward zero)
    task automatic md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ua, ub, up;
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        h = 32'd0;
        l = 32'd0;
        if (op == 3'd1) begin
            sp = sa * sb; h = sp[63:32]; l = sp[31:0];
        end else if (op == 3'd2) begin
            up = ua * ub; h = up[63:32]; l = up[31:0];
        end else if (b == 32'd0) begin
            h = a; l = 32'hFFFF_FFFF;
        end else if (op == 3'd3) begin
            sp = sa / sb; l = sp[31:0];
            sp = sa % sb; h = sp[31:0];
        end else begin
            up = ua / ub; l = up[31:0];
            up = ua % ub; h = up[31:0];
        end
    endtask

    function automatic bit is_start(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    function automatic bit stall_now();
        return (busy_left > 0) && (is_start(MDOpE) || MDOpE == 3'd5 || MDOpE == 3'd6);
    endfunction

    task automatic model_reset();
        busy_left = 0;
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0;
        e_alu = 0; e_wd = 0; e_wr = 0; e_rw = 0; e_mtr = 0; e_mw = 0;
    endtask

    task automatic model_edge();
        logic [31:0] sa, wd, sb, res;
        bit st;
        st  = stall_now();
        sa  = fwd(ForwardAE, RD1_E);
        wd  = fwd(ForwardBE, RD2_E);
        sb  = ALUSrcE ? SignImmE : wd;
        res = (MDOpE == 3'd5) ? m_hi : (MDOpE == 3'd6) ? m_lo : alu_ref(ALUControlE, sa, sb);
        if (st) begin
            e_rw = 0; e_mtr = 0; e_mw = 0; e_wr = 0;
        end else begin
            e_alu = res; e_wd = wd; e_wr = RegDstE ? RdE : RtE;
            e_rw = RegWriteE && !is_start(MDOpE); e_mtr = MemtoRegE; e_mw = MemWriteE;
        end
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (MD_EN && is_start(MDOpE)) begin
            md_ref(MDOpE, sa, sb, p_hi, p_lo);
            busy_left = 32;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_nop();
        ALUControlE = 0; MDOpE = 0; RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0;
        RegDstE = 0; ALUSrcE = 0; RD1_E = 0; RD2_E = 0; SignImmE = 0; ResultW = 0;
        RsE = 0; RtE = 0; RdE = 0; ForwardAE = 0; ForwardBE = 0;
    endtask

    task automatic set_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        set_nop();
        ALUControlE = c; RD1_E = a; RD2_E = b; RegWriteE = 1; RegDstE = 1; RdE = rd;
    endtask

    task automatic set_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        set_nop();
        MDOpE = op; RD1_E = a; RD2_E = b; RegWriteE = 1; RtE = 5'd31;
    endtask

    task automatic set_mf(input logic [2:0] op, input logic [4:0] rd);
        set_nop();
        MDOpE = op; RegWriteE = 1; RegDstE = 1; RdE = rd;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        set_nop();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        model_reset();
        n_checks++;
        if ({RegWriteM, MemtoRegM, MemWriteM, MDBusy, StallE} !== 5'b0) begin
            n_errors++; $display("FAIL reset_ctrl: got %b want 00000", {RegWriteM, MemtoRegM, MemWriteM, MDBusy, StallE});
        end
        n_checks++;
        if ({ALUOutM, WriteDataM, WriteRegM} !== 69'd0) begin
            n_errors++; $display("FAIL reset_data: got %h %h %h want 0", ALUOutM, WriteDataM, WriteRegM);
        end
        RST = 1'b1;
    endtask

    task automatic test_alu();
        set_alu(3'd2, 32'd5, 32'd7, 5'd9);
        tick();
        n_checks++;
        if ({ALUOutM, WriteRegM, RegWriteM} !== {32'd12, 5'd9, 1'b1}) begin
            n_errors++; $display("FAIL add: got %h/%0d/%b want 0000000c/9/1", ALUOutM, WriteRegM, RegWriteM);
        end
        set_alu(3'd6, 32'd3, 32'd5, 5'd4);
        tick();
        n_checks++;
        if (ALUOutM !== 32'hFFFF_FFFE) begin
            n_errors++; $display("FAIL sub: got %h want fffffffe", ALUOutM);
        end
        set_alu(3'd7, 32'hFFFF_FFFF, 32'd1, 5'd5);
        tick();
        n_checks++;
        if (ALUOutM !== 32'd1) begin
            n_errors++; $display("FAIL slt: got %h want 00000001", ALUOutM);
        end
    endtask

    task automatic test_forwarding();
        set_alu(3'd2, 32'd5, 32'd7, 5'd9);
        tick();
        set_alu(3'd2, 32'd100, 32'd1, 5'd3);
        ForwardAE = 2'b10;
        tick();
        n_checks++;
        if (ALUOutM !== 32'd13) begin
            n_errors++; $display("FAIL fwd_alu: got %h want 0000000d", ALUOutM);
        end
        set_nop();
        ForwardBE = 2'b01; ResultW = 32'hA5; RD2_E = 32'h33; MemWriteE = 1;
        tick();
        n_checks++;
        if ({WriteDataM, MemWriteM} !== {32'hA5, 1'b1}) begin
            n_errors++; $display("FAIL fwd_wd: got %h/%b want 000000a5/1", WriteDataM, MemWriteM);
        end
        set_alu(3'd1, 32'hFF, 32'h0F, 5'd2);
        ForwardAE = 2'b11;
        tick();
        n_checks++;
        if (ALUOutM !== 32'h0F) begin
            n_errors++; $display("FAIL fwd_zero: got %h want 0000000f", ALUOutM);
        end
    endtask

    task automatic test_random_alu();
        logic [2:0] ops [6];
        ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd2; ops[3] = 3'd6; ops[4] = 3'd7; ops[5] = 3'd3;
        for (int i = 0; i < 40; i++) begin
            set_nop();
            ALUControlE = ops[$urandom_range(0, 5)];
            RD1_E = $urandom; RD2_E = $urandom; SignImmE = $urandom; ResultW = $urandom;
            if ($urandom_range(0, 1) == 1) RD1_E = 32'($urandom_range(0, 8)) - 32'd4;
            ForwardAE = 2'($urandom_range(0, 3)); ForwardBE = 2'($urandom_range(0, 3));
            ALUSrcE = 1'($urandom_range(0, 1)); RegDstE = 1'($urandom_range(0, 1));
            RegWriteE = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
            MemWriteE = 1'($urandom_range(0, 1));
            RtE = 5'($urandom); RdE = 5'($urandom); RsE = 5'($urandom);
            tick();
            n_checks++;
            if ({ALUOutM, WriteDataM} !== {e_alu, e_wd}) begin
                n_errors++; $display("FAIL rand_alu_data[%0d]: got %h %h want %h %h", i, ALUOutM, WriteDataM, e_alu, e_wd);
            end
            n_checks++;
            if ({RegWriteM, MemtoRegM, MemWriteM, WriteRegM} !== {e_rw, e_mtr, e_mw, e_wr}) begin
                n_errors++; $display("FAIL rand_alu_ctrl[%0d]: got %b want %b", i,
                    {RegWriteM, MemtoRegM, MemWriteM, WriteRegM}, {e_rw, e_mtr, e_mw, e_wr});
            end
        end
    endtask

    task automatic test_mult_mflo();
        int n;
        set_md(3'd1, 32'hFFFF_FFFD, 32'd4);
        n_checks++;
        if (StallE !== 1'b0) begin
            n_errors++; $display("FAIL mult_issue_stall: got %b want 0", StallE);
        end
        tick();
        n_checks++;
        if ({RegWriteM, MDBusy} !== {1'b0, MD_EN}) begin
            n_errors++; $display("FAIL mult_issue: got rw/busy %b want 0%b", {RegWriteM, MDBusy}, MD_EN);
        end
        set_mf(3'd6, 5'd8);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (StallE !== 1'b1) break;
            n_checks++;
            if ({MDBusy, 1'(stall_now())} !== 2'b11) begin
                n_errors++; $display("FAIL mflo_stall_cycle[%0d]: got busy %b want 1, model stall %b", i, MDBusy, stall_now());
            end
            tick();
            n_checks++;
            if ({RegWriteM, WriteRegM} !== 6'd0) begin
                n_errors++; $display("FAIL mflo_bubble[%0d]: got %b want 000000", i, {RegWriteM, WriteRegM});
            end
            n++;
        end
        n_checks++;
        if (n != (MD_EN ? 32 : 0) || MDBusy !== 1'b0) begin
            n_errors++; $display("FAIL mult_stall_len: got %0d busy %b want %0d busy 0", n, MDBusy, MD_EN ? 32 : 0);
        end
        tick();
        n_checks++;
        if ({ALUOutM, RegWriteM, WriteRegM} !== {(MD_EN ? 32'hFFFF_FFF4 : 32'd0), 1'b1, 5'd8}) begin
            n_errors++; $display("FAIL mflo: got %h/%b/%0d want %h/1/8", ALUOutM, RegWriteM, WriteRegM, MD_EN ? 32'hFFFF_FFF4 : 32'd0);
        end
        set_mf(3'd5, 5'd9);
        tick();
        n_checks++;
        if (ALUOutM !== (MD_EN ? 32'hFFFF_FFFF : 32'd0)) begin
            n_errors++; $display("FAIL mfhi: got %h want %h", ALUOutM, MD_EN ? 32'hFFFF_FFFF : 32'd0);
        end
    endtask

    task automatic test_divide();
        logic [2:0]  op [3];
        logic [31:0] a [3], b [3], lo [3], hi [3];
        int lat;
        op[0] = 3'd4; a[0] = 32'd100;        b[0] = 32'd7; lo[0] = 32'd14;          hi[0] = 32'd2;
        op[1] = 3'd3; a[1] = 32'hFFFF_FFF9;  b[1] = 32'd2; lo[1] = 32'hFFFF_FFFD;   hi[1] = 32'hFFFF_FFFF;
        op[2] = 3'd3; a[2] = 32'd9;          b[2] = 32'd0; lo[2] = 32'hFFFF_FFFF;   hi[2] = 32'd9;
        for (int k = 0; k < 3; k++) begin
            set_md(op[k], a[k], b[k]);
            tick();
            set_nop();
            lat = 0;
            for (int i = 0; i < 100; i++) begin
                if (MDBusy !== 1'b1) break;
                tick();
                lat++;
            end
            n_checks++;
            if (lat != (MD_EN ? 32 : 0)) begin
                n_errors++; $display("FAIL div_latency[%0d]: got %0d want %0d", k, lat, MD_EN ? 32 : 0);
            end
            set_mf(3'd6, 5'd1);
            tick();
            n_checks++;
            if (ALUOutM !== (MD_EN ? lo[k] : 32'd0)) begin
                n_errors++; $display("FAIL div_lo[%0d]: got %h want %h", k, ALUOutM, MD_EN ? lo[k] : 32'd0);
            end
            set_mf(3'd5, 5'd1);
            tick();
            n_checks++;
            if (ALUOutM !== (MD_EN ? hi[k] : 32'd0)) begin
                n_errors++; $display("FAIL div_hi[%0d]: got %h want %h", k, ALUOutM, MD_EN ? hi[k] : 32'd0);
            end
        end
    endtask

    task automatic test_busy_flow();
        int n;
        set_md(3'd1, 32'd6, 32'd7);
        tick();
        set_alu(3'd2, 32'd20, 32'd22, 5'd3);
        n_checks++;
        if (StallE !== 1'b0) begin
            n_errors++; $display("FAIL add_busy_stall: got %b want 0", StallE);
        end
        tick();
        n_checks++;
        if ({ALUOutM, RegWriteM, MDBusy} !== {32'd42, 1'b1, MD_EN}) begin
            n_errors++; $display("FAIL add_busy: got %h/%b/%b want 0000002a/1/%b", ALUOutM, RegWriteM, MDBusy, MD_EN);
        end
        set_md(3'd1, 32'd2, 32'd3);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (StallE !== 1'b1) break;
            tick();
            n++;
        end
        n_checks++;
        if (n != (MD_EN ? 31 : 0)) begin
            n_errors++; $display("FAIL mult2_stall_len: got %0d want %0d", n, MD_EN ? 31 : 0);
        end
        tick();
        n_checks++;
        if ({MDBusy, RegWriteM} !== {MD_EN, 1'b0}) begin
            n_errors++; $display("FAIL mult2_issue: got %b want %b0", {MDBusy, RegWriteM}, MD_EN);
        end
        set_mf(3'd6, 5'd4);
        for (int i = 0; i < 100; i++) begin
            if (StallE !== 1'b1) break;
            tick();
        end
        tick();
        n_checks++;
        if (ALUOutM !== (MD_EN ? 32'd6 : 32'd0)) begin
            n_errors++; $display("FAIL mult2_lo: got %h want %h", ALUOutM, MD_EN ? 32'd6 : 32'd0);
        end
    endtask

    task automatic test_reset_mid_div();
        set_md(3'd3, 32'd1000, 32'd3);
        tick();
        set_alu(3'd2, 32'd1, 32'd2, 5'd1);
        for (int i = 0; i < 9; i++) tick();
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({MDBusy, StallE, RegWriteM, ALUOutM, WriteDataM, WriteRegM} !== 72'd0) begin
            n_errors++; $display("FAIL reset_mid_div: got busy %b rw %b alu %h wd %h wr %0d want 0",
                MDBusy, RegWriteM, ALUOutM, WriteDataM, WriteRegM);
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        set_mf(3'd6, 5'd7);
        n_checks++;
        if (StallE !== 1'b0) begin
            n_errors++; $display("FAIL post_reset_stall: got %b want 0", StallE);
        end
        tick();
        n_checks++;
        if ({ALUOutM, RegWriteM, WriteRegM} !== {32'd0, 1'b1, 5'd7}) begin
            n_errors++; $display("FAIL post_reset_mflo: got %h/%b/%0d want 0/1/7", ALUOutM, RegWriteM, WriteRegM);
        end
    endtask

    task automatic test_random_md();
        logic [2:0]  op;
        logic [31:0] a, b, h, l;
        for (int k = 0; k < 10; k++) begin
            op = 3'($urandom_range(1, 4));
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, 200)) - 32'd100;
            if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 20)) - 32'd10;
            if ($urandom_range(0, 3) == 0) b = 32'd0;
            md_ref(op, a, b, h, l);
            set_md(op, a, b);
            tick();
            set_mf(3'd6, 5'd2);
            for (int i = 0; i < 100; i++) begin
                if (StallE !== 1'b1) break;
                tick();
            end
            tick();
            n_checks++;
            if (ALUOutM !== (MD_EN ? l : 32'd0)) begin
                n_errors++; $display("FAIL rand_md_lo[%0d] op %0d a %h b %h: got %h want %h", k, op, a, b, ALUOutM, MD_EN ? l : 32'd0);
            end
            set_mf(3'd5, 5'd2);
            tick();
            n_checks++;
            if (ALUOutM !== (MD_EN ? h : 32'd0)) begin
                n_errors++; $display("FAIL rand_md_hi[%0d] op %0d a %h b %h: got %h want %h", k, op, a, b, ALUOutM, MD_EN ? h : 32'd0);
            end
        end
    endtask

    initial begin
        RST = 1'b0;
        set_nop();
        model_reset();
        test_reset();
        test_alu();
        test_forwarding();
        test_random_alu();
        test_mult_mflo();
        test_divide();
        test_busy_flow();
        test_reset_mid_div();
        test_random_md();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/execute_stage_md.md
# execute_stage_md

Parametrised successor to the single-cycle execute stage of the 5-stage MIPS pipeline. It keeps the ALU and the forwarding muxes (SrcA/SrcB/WriteData), and adds three things:
- an iterative multiply/divide unit with HI/LO registers;
- a stall handshake to the hazard unit;
- the EX/MEM pipeline register, so the stage is self-contained between the decode register and memory.

## Interface
- WIDTH, 32: datapath width; must be even, ≥ 8.
- REG_ADDR_WIDTH, 5: register index width.
- ALU_CONTROL_WIDTH, 3: ALU opcode width.
- CLK  in  1  rising-edge clock.
- RST  in  1  reset; asynchronous assertion, active-low.
- ALUControlE  in  ALU_CONTROL_WIDTH  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed); others give 0.
- MDOpE  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MFHI, 110 MFLO, 111 none.
- RegWriteE, MemtoRegE, MemWriteE, RegDstE, ALUSrcE  in  1 each  decode control.
- RD1_E, RD2_E, SignImmE, ResultW  in  WIDTH  register operands, immediate, WB forward value.
- RsE, RtE, RdE  in  REG_ADDR_WIDTH  register indices.
- ForwardAE, ForwardBE  in  2  forward select: 00 register file, 01 ResultW, 10 ALUOutM, 11 zero.
- StallE  out  1  combinational; E instruction must be held this cycle.
- MDBusy  out  1  registered; iteration in progress.
- RegWriteM, MemtoRegM, MemWriteM  out  1 each  registered control.
- ALUOutM, WriteDataM  out  WIDTH  registered result and store data.
- WriteRegM  out  REG_ADDR_WIDTH  registered destination.

## Operation
- SrcA = mux4(ForwardAE) of RD1_E, ResultW, ALUOutM, 0.
- WriteData = mux4(ForwardBE) of RD2_E, ResultW, ALUOutM, 0.
- SrcB = ALUSrcE ? SignImmE : WriteData.
- WriteReg = RegDstE ? RdE : RtE.
- ALUOutM forwarding uses this block's own M register; there is no external ALUOutM input.
- Result selection: MFHI → HI, MFLO → LO, otherwise the ALU result.
- FSM states and transitions:
  - IDLE → MUL on MULT/MULTU when not stalled; → DIV on DIV/DIVU when not stalled.
  - MUL/DIV → IDLE when the iteration counter reaches WIDTH.
- Operand latching on issue:
  - Signed ops latch |SrcA| and |SrcB| plus the result sign bits.
  - The counter width is $clog2(WIDTH+1).
- MUL is radix-2 shift-add, one bit per cycle. DIV is restoring division, one quotient bit per cycle.
- On the final iteration edge, sign correction is applied and HI/LO are written:
  - MUL: HI = upper WIDTH bits, LO = lower WIDTH bits.
  - DIV: LO = quotient, HI = remainder; the remainder takes the dividend's sign.
- Divide by zero: LO = all ones, HI = dividend, same latency.
- A MULT/DIV/MULTU/DIVU instruction does not itself stall. It writes no register: RegWriteM is forced 0 for it.
- StallE = MDBusy AND (MDOpE ∈ {MULT, MULTU, DIV, DIVU, MFHI, MFLO}). All other instructions flow through while busy.
- While StallE = 1, the M register loads a bubble: RegWriteM = MemtoRegM = MemWriteM = 0, WriteRegM = 0, data regs hold.
- Unsigned MULTU/DIVU treat operands as unsigned. SLT compares signed. ADD/SUB wrap modulo 2^WIDTH with no overflow trap.

## Timing
- ALU path: operands present in cycle n → M outputs valid after the edge ending cycle n (1-cycle latency).
- MD issue in cycle 0:
  - MDBusy = 1 from the edge ending cycle 0.
  - Iterations occur on the edges ending cycles 1..WIDTH.
  - HI/LO update and MDBusy = 0 at the edge ending cycle WIDTH.
- A dependent MFHI/MFLO stalls through cycles 1..WIDTH and completes in cycle WIDTH+1.
- Back-to-back MD ops: the second issues in cycle WIDTH+1.
- StallE is combinational from MDBusy and MDOpE, valid in the same cycle.
- Reset (RST low, any time):
  - All M outputs, HI, LO and MDBusy are 0; FSM is IDLE; counter is 0.
  - An in-flight operation is aborted and HI/LO are cleared.
- Release of RST is synchronous to CLK.

## Configuration
- Macro EXECUTE_MD_UNIT_EN.
- Defined: MD unit, HI/LO and the stall logic are present, as above.
- Undefined:
  - No FSM and no HI/LO registers.
  - MDBusy = 0, StallE = 0.
  - MFHI/MFLO return 0.
  - MULT/DIV-class ops behave as a NOP bubble (RegWriteM = 0).
  - The ALU path is unchanged.

## Test plan
- Reset and ALU ops, WIDTH=32: reset → all outputs 0. Then:
  - ADD with RD1_E=5, RD2_E=7, ALUSrcE=0, RegDstE=1, RdE=9 → ALUOutM=12, WriteRegM=9, RegWriteM=1 next cycle.
  - SUB 3−5 → ALUOutM=0xFFFFFFFE.
  - SLT −1<1 → ALUOutM=1.
- Forwarding: ForwardAE=10 with ALUOutM=12 and ADD with RD2_E=1 → ALUOutM=13. ForwardBE=01 with ResultW=0xA5, MemWriteE=1 → WriteDataM=0xA5.
- MULT −3×4 followed by MFLO:
  - MDBusy high for 32 cycles; StallE high for the MFLO for 32 cycles with bubbles in M.
  - Then ALUOutM=0xFFFFFFF4; a following MFHI → 0xFFFFFFFF.
- Divide cases:
  - DIVU 100/7 → LO=14, HI=2.
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 9/0 → LO=0xFFFFFFFF, HI=9, latency 32 cycles.
- Independent ADD issued during busy → no stall, result 1 cycle later.
- Second MULT during busy → stalls until MDBusy falls.
- Assert RST in cycle 10 of a DIV → MDBusy=0, HI=LO=0 immediately. After release, MFLO → 0 with no stall.
